// File: rtl/sat_counter_table.sv
// Table of DEPTH saturating counters with a registered, indexed prediction port and
// an indexed training port. The whole table is rewritten sequentially after reset or clear.
module sat_counter_table #(
  parameter int CTR_W    = 2,
  parameter int IDX_W    = 10,
  parameter int INIT_VAL = 0
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             clear,
  output logic             ready,
  input  logic             pred_req,
  input  logic [IDX_W-1:0] pred_idx,
  output logic             pred_vld,
  output logic             pred_taken,
  output logic             pred_strong,
  output logic [CTR_W-1:0] pred_ctr,
  input  logic             upd_req,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] MAX      = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(INIT_VAL);
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] init_ptr, next_ptr;
  logic             init_we;
  logic             upd_we;
  logic             pred_acc;

  logic [CTR_W-1:0] mem [DEPTH];
  logic [CTR_W-1:0] upd_cur;
  logic [CTR_W-1:0] upd_next;
  logic [CTR_W-1:0] rd_val;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state    <= next_state;
      init_ptr <= next_ptr;
    end
  end

  always_comb begin
    next_state = state;
    next_ptr   = init_ptr;
    init_we    = 1'b0;
    upd_we     = 1'b0;
    ready      = 1'b0;
    case (state)
      INIT: begin
        // a clear while initialising restarts the sweep without writing this cycle
        if (clear) begin
          next_ptr = '0;
        end else begin
          init_we  = 1'b1;
          next_ptr = init_ptr + 1'b1;
          if (init_ptr == LAST_IDX) next_state = RUN;
        end
      end
      RUN: begin
        ready = 1'b1;
        if (clear) begin
          next_state = INIT;
          next_ptr   = '0;
        end else begin
          upd_we = upd_req;
        end
      end
      default: begin
        next_state = INIT;
        next_ptr   = '0;
      end
    endcase
  end

  always_comb begin
    upd_cur  = mem[upd_idx];
    upd_next = upd_cur;
    if (upd_taken) begin
      if (upd_cur != MAX) upd_next = upd_cur + 1'b1;
    end else begin
      if (upd_cur != '0) upd_next = upd_cur - 1'b1;
    end
  end

  // Array is deliberately left without reset; the INIT sweep defines its contents.
  always_ff @(posedge clock) begin
    if (resetN) begin
      if (init_we) begin
        mem[init_ptr] <= INIT_CTR;
      end else if (upd_we) begin
        mem[upd_idx] <= upd_next;
      end
    end
  end

  assign pred_acc = pred_req & ready;
  assign rd_val   = mem[pred_idx];

  always_ff @(posedge clock) begin
    if (!resetN) begin
      pred_vld    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_strong <= 1'b0;
      pred_ctr    <= '0;
    end else begin
      pred_vld <= pred_acc;
      if (pred_acc) begin
        pred_ctr    <= rd_val;
        pred_taken  <= rd_val[CTR_W-1];
        pred_strong <= (rd_val == '0) || (rd_val == MAX);
      end
    end
  end

endmodule

// File: tb/tb_sat_counter_table.sv
// Bench for sat_counter_table: a 2-bit/8-entry table with directed and random traffic,
// plus a 3-bit table with a non-zero initial value.
module tb_sat_counter_table;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetN, clear, pred_req, upd_req, upd_taken;
  logic [2:0] pred_idx, upd_idx;
  logic       ready, pred_vld, pred_taken, pred_strong;
  logic [1:0] pred_ctr;

  logic       b_resetN, b_clear, b_pred_req, b_upd_req, b_upd_taken;
  logic [2:0] b_pred_idx, b_upd_idx;
  logic       b_ready, b_pred_vld, b_pred_taken, b_pred_strong;
  logic [2:0] b_pred_ctr;

  sat_counter_table #(.CTR_W(2), .IDX_W(3), .INIT_VAL(0)) dut_a (
    .clock(clock), .resetN(resetN), .clear(clear), .ready(ready),
    .pred_req(pred_req), .pred_idx(pred_idx), .pred_vld(pred_vld),
    .pred_taken(pred_taken), .pred_strong(pred_strong), .pred_ctr(pred_ctr),
    .upd_req(upd_req), .upd_idx(upd_idx), .upd_taken(upd_taken)
  );

  sat_counter_table #(.CTR_W(3), .IDX_W(3), .INIT_VAL(3)) dut_b (
    .clock(clock), .resetN(b_resetN), .clear(b_clear), .ready(b_ready),
    .pred_req(b_pred_req), .pred_idx(b_pred_idx), .pred_vld(b_pred_vld),
    .pred_taken(b_pred_taken), .pred_strong(b_pred_strong), .pred_ctr(b_pred_ctr),
    .upd_req(b_upd_req), .upd_idx(b_upd_idx), .upd_taken(b_upd_taken)
  );

  int tests = 0;
  int fails = 0;

  // Reference state: counter values as integers, cycles of initialisation left,
  // and the prediction outputs the table should currently be showing.
  int ma[8];
  int a_left, a_ctr;
  bit a_vld, a_taken, a_strong;
  int mb[8];
  int b_left, b_ctr;
  bit b_vld, b_taken, b_strong;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int train(input int v, input bit t, input int mx);
    if (t) return (v < mx) ? v + 1 : mx;
    return (v > 0) ? v - 1 : 0;
  endfunction

  task automatic op_a(input bit rst, input bit clr, input bit p, input int pi,
                      input bit u, input int ui, input bit ut);
    resetN = !rst; clear = clr;
    pred_req = p; pred_idx = 3'(pi);
    upd_req = u; upd_idx = 3'(ui); upd_taken = ut;
    if (rst) begin
      a_vld = 0; a_ctr = 0; a_taken = 0; a_strong = 0; a_left = 8;
      foreach (ma[i]) ma[i] = 0;
    end else begin
      a_vld = p && (a_left == 0);
      if (a_vld) begin
        a_ctr    = ma[pi];
        a_taken  = (a_ctr >= 2);
        a_strong = (a_ctr == 0) || (a_ctr == 3);
      end
      if (clr) begin
        a_left = 8;
        foreach (ma[i]) ma[i] = 0;
      end else if (a_left > 0) begin
        a_left--;
      end else if (u) begin
        ma[ui] = train(ma[ui], ut, 3);
      end
    end
    @(posedge clock); #1;
    chk("a_ready", ready, a_left == 0);
    chk("a_vld", pred_vld, a_vld);
    chk("a_ctr", pred_ctr, a_ctr);
    chk("a_taken", pred_taken, a_taken);
    chk("a_strong", pred_strong, a_strong);
  endtask

  task automatic idle_a();
    op_a(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic op_b(input bit rst, input bit p, input int pi,
                      input bit u, input int ui, input bit ut);
    b_resetN = !rst; b_clear = 0;
    b_pred_req = p; b_pred_idx = 3'(pi);
    b_upd_req = u; b_upd_idx = 3'(ui); b_upd_taken = ut;
    if (rst) begin
      b_vld = 0; b_ctr = 0; b_taken = 0; b_strong = 0; b_left = 8;
      foreach (mb[i]) mb[i] = 3;
    end else begin
      b_vld = p && (b_left == 0);
      if (b_vld) begin
        b_ctr    = mb[pi];
        b_taken  = (b_ctr >= 4);
        b_strong = (b_ctr == 0) || (b_ctr == 7);
      end
      if (b_left > 0) b_left--;
      else if (u) mb[ui] = train(mb[ui], ut, 7);
    end
    @(posedge clock); #1;
    chk("b_ready", b_ready, b_left == 0);
    chk("b_vld", b_pred_vld, b_vld);
    chk("b_ctr", b_pred_ctr, b_ctr);
    chk("b_taken", b_pred_taken, b_taken);
    chk("b_strong", b_pred_strong, b_strong);
  endtask

  initial begin
    resetN = 0; clear = 0; pred_req = 0; pred_idx = 0;
    upd_req = 0; upd_idx = 0; upd_taken = 0;

    // wide counter with non-zero initial value, while the narrow table sits in reset
    op_b(1, 0, 0, 0, 0, 0);
    op_b(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) op_b(0, 0, 0, 0, 0, 0);
    op_b(0, 1, 0, 0, 0, 0);
    op_b(0, 0, 0, 1, 0, 1);
    op_b(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) op_b(0, 0, 0, 1, 0, 1);
    op_b(0, 1, 0, 0, 0, 0);
    op_b(0, 0, 0, 1, 0, 0);
    op_b(0, 1, 0, 0, 0, 0);
    op_b(1, 0, 0, 0, 0, 0);

    // reset and initialisation; requests during INIT are ignored
    op_a(1, 0, 0, 0, 0, 0, 0);
    op_a(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) op_a(0, 0, 1, i, 1, i, 1);
    for (int i = 0; i < 8; i++) op_a(0, 0, 1, i, 0, 0, 0);
    idle_a();

    // saturation up and down on index 5
    for (int i = 0; i < 4; i++) begin
      op_a(0, 0, 0, 0, 1, 5, 1);
      op_a(0, 0, 1, 5, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      op_a(0, 0, 0, 0, 1, 5, 0);
      op_a(0, 0, 1, 5, 0, 0, 0);
    end

    // read-during-write on index 2
    op_a(0, 0, 0, 0, 1, 2, 1);
    op_a(0, 0, 1, 2, 1, 2, 1);
    op_a(0, 0, 1, 2, 0, 0, 0);

    // back-to-back updates to index 3
    op_a(0, 0, 0, 0, 1, 3, 1);
    op_a(0, 0, 0, 0, 1, 3, 1);
    op_a(0, 0, 1, 3, 1, 3, 0);
    op_a(0, 0, 1, 3, 0, 0, 0);

    // clear: same-cycle predict answered, update dropped, clear again mid-INIT
    for (int i = 0; i < 3; i++) op_a(0, 0, 0, 0, 1, 1, 1);
    op_a(0, 1, 1, 1, 1, 1, 1);
    op_a(0, 0, 0, 0, 1, 1, 1);
    op_a(0, 0, 1, 1, 1, 1, 1);
    idle_a();
    op_a(0, 1, 0, 0, 1, 1, 1);
    for (int i = 0; i < 8; i++) op_a(0, 0, 0, 0, 1, 1, 1);
    op_a(0, 0, 1, 1, 0, 0, 0);
    idle_a();

    // reset during RUN with a prediction request at the same edge
    op_a(0, 0, 0, 0, 1, 4, 1);
    op_a(0, 0, 1, 4, 0, 0, 0);
    op_a(1, 0, 1, 4, 0, 0, 0);
    for (int i = 0; i < 8; i++) op_a(0, 0, 1, 4, 0, 0, 0);
    op_a(0, 0, 1, 4, 0, 0, 0);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      op_a($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 7),
           $urandom_range(0, 3) != 0, $urandom_range(0, 7),
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sat_counter_table.md
Name: sat_counter_table

Overview:
- Parametrised table of DEPTH n-bit saturating counters, used as the pattern-history / choice storage of the tournament predictor.
- Generalises the single 2-bit counter:
  - configurable counter width, table depth and reset value;
  - indexed predict and update ports;
  - registered prediction with confidence output;
  - sequential table-initialisation engine used on reset and on pipeline flush.
- One instance each serves the local, global and choice predictors.

Parameters:
- CTR_W, 2: counter width in bits, ≥1. Maximum value is MAX = 2^CTR_W - 1.
- IDX_W, 10: index width. DEPTH = 2^IDX_W entries.
- INIT_VAL, 0: value written to every entry on reset or clear. Must be ≤ MAX.

Ports:
- clock  in  1  clock, rising edge.
- resetN  in  1  reset: synchronous, active-low.
- clear  in  1  request re-initialisation of the whole table.
- ready  out  1  table accepting predict/update requests.
- pred_req  in  1  prediction request.
- pred_idx  in  IDX_W  prediction index.
- pred_vld  out  1  prediction result valid.
- pred_taken  out  1  counter MSB of the addressed entry.
- pred_strong  out  1  addressed counter is 0 or MAX.
- pred_ctr  out  CTR_W  raw counter value.
- upd_req  in  1  training request.
- upd_idx  in  IDX_W  training index.
- upd_taken  in  1  resolved branch outcome.

Behaviour:
- FSM states: INIT, RUN.
- Reset (resetN=0 at a rising edge):
  - state<=INIT, init_ptr<=0;
  - ready=0, pred_vld=0, pred_taken=0, pred_strong=0, pred_ctr=0.
  - Array contents are not reset directly.
- INIT:
  - Each cycle: entry[init_ptr]<=INIT_VAL, init_ptr++.
  - After writing entry DEPTH-1, state<=RUN.
  - INIT lasts exactly DEPTH cycles after the reset/clear edge.
  - ready=0 throughout. pred_req and upd_req are ignored: no result, no write.
- RUN: ready=1.
- clear:
  - In RUN, clear=1 moves the FSM to INIT with init_ptr<=0 next cycle.
  - In INIT, clear=1 restarts init_ptr at 0.
  - clear has priority over a same-cycle update: the update is dropped.
  - A same-cycle prediction is still answered normally.
- Prediction:
  - pred_req=1 with ready=1 at edge t gives pred_vld=1 during cycle t+1 (latency 1).
  - pred_ctr = entry[pred_idx] as it stood before edge t's update.
  - pred_taken = pred_ctr[CTR_W-1].
  - pred_strong = (pred_ctr==0) or (pred_ctr==MAX).
  - pred_vld=0 in any cycle not following an accepted request. pred_ctr/taken/strong hold their last values when pred_vld=0.
- Update:
  - upd_req=1 with ready=1 at edge t writes entry[upd_idx] at edge t.
  - upd_taken=1: +1, saturating at MAX.
  - upd_taken=0: -1, saturating at 0.
  - No wrap-around ever.
- Read-during-write:
  - Same index, same edge: prediction returns the old value.
  - A prediction issued at edge t+1 sees the update from edge t.
- Back-to-back updates to the same index on consecutive edges each apply fully. No lost updates.
- CTR_W=1 degenerates to a last-outcome bit: pred_strong is always 1.
- resetN=0 mid-INIT or mid-RUN restarts INIT from index 0 and aborts any pending pred_vld.

Test Plan (IDX_W=3, CTR_W=2, INIT_VAL=0 unless stated):
- Reset, then hold 8 cycles: ready=0 for exactly 8 cycles after the reset edge, then 1. Predict all 8 indices: each pred_ctr=0, taken=0, strong=1.
- Idx 5: 4× upd_taken=1 → pred_ctr sequence 1,2,3,3 (saturates). taken=1 from value 2; strong only at 3. Then 4× upd_taken=0 → 2,1,0,0.
- Same edge: pred_idx=2 and upd_idx=2 taken from value 1 → pred_ctr=1. Next-cycle predict of idx 2 → 2.
- Train idx 1 to 3, then assert clear → ready low 8 cycles, update issued during INIT dropped, idx 1 reads 0 afterwards. clear again mid-INIT → INIT extends to 8 cycles from the second clear.
- CTR_W=3, INIT_VAL=3: reset → idx 0 reads 3, taken=0, strong=0. One taken update → 4, taken=1. Seven more taken updates → 7, strong=1.
- resetN pulsed low during RUN with a prediction outstanding → pred_vld=0 next cycle, ready=0, full 8-cycle INIT repeats.
